// File: rtl/triangle_list_if.sv
// Triangle list bus: write port, list control, readout handshake and status.
interface triangle_list_if #(
   parameter int WI    = 8,
   parameter int WF    = 8,
   parameter int DEPTH = 16
) ();
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                            list_w;
   logic [2:0][2:0][WI+WF-1:0]      orig_triangle_in;
   logic                            list_clear;
   logic                            frame_start;
   logic                            tri_ready;
   logic [2:0][2:0][WI+WF-1:0]      tri_out;
   logic                            tri_valid;
   logic                            frame_done;
   logic [AW:0]                     tri_count;
   logic                            full;
   logic                            overflow;

   modport master (
      output list_w, orig_triangle_in, list_clear, frame_start, tri_ready,
      input  tri_out, tri_valid, frame_done, tri_count, full, overflow
   );

   modport slave (
      input  list_w, orig_triangle_in, list_clear, frame_start, tri_ready,
      output tri_out, tri_valid, frame_done, tri_count, full, overflow
   );
endinterface

// File: rtl/triangle_list.sv
// Triangle list: stores up to DEPTH triangles in write order and replays them
// downstream one pass per frame_start with a valid/ready handshake.
// Optional macro TRI_LIST_SKIP_DEGENERATE_EN drops triangles that have two
// bit-identical vertices at write time.
module triangle_list #(
   parameter int WI    = 8,
   parameter int WF    = 8,
   parameter int DEPTH = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   triangle_list_if.slave  bus
);
   localparam int W  = WI + WF;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

   state_t                   state_q, state_d;
   logic [2:0][2:0][W-1:0]   mem [DEPTH];
   logic [2:0][2:0][W-1:0]   tri_out_q;
   logic [AW:0]              cnt_q;
   logic [AW:0]              frame_len_q;
   logic [AW:0]              last_idx;
   logic [AW-1:0]            idx_q;
   logic                     overflow_q;
   logic                     full;
   logic                     degen;
   logic                     wr_en;
   logic                     last;

   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign last_idx = frame_len_q - (AW+1)'(1);
   assign last     = ({1'b0, idx_q} == last_idx);

`ifdef TRI_LIST_SKIP_DEGENERATE_EN
   assign degen = (bus.orig_triangle_in[0] == bus.orig_triangle_in[1]) ||
                  (bus.orig_triangle_in[0] == bus.orig_triangle_in[2]) ||
                  (bus.orig_triangle_in[1] == bus.orig_triangle_in[2]);
`else
   assign degen = 1'b0;
`endif

   assign wr_en = bus.list_w && !bus.list_clear && !full && !degen;

   assign bus.tri_out    = tri_out_q;
   assign bus.tri_valid  = (state_q == PRESENT);
   assign bus.frame_done = (state_q == DONE);
   assign bus.tri_count  = cnt_q;
   assign bus.full       = full;
   assign bus.overflow   = overflow_q;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge Clk) begin
      if (wr_en)
         mem[cnt_q[AW-1:0]] <= bus.orig_triangle_in;
   end

   // Fill count and sticky overflow; clear outranks any write.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else if (bus.list_clear) begin
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else if (bus.list_w && !degen) begin
         if (full)
            overflow_q <= 1'b1;
         else
            cnt_q <= cnt_q + (AW+1)'(1);
      end
   end

   // Readout state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Readout next-state; list_clear returns to Idle from anywhere.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.frame_start) state_d = (cnt_q != '0) ? FETCH : DONE;
         FETCH:   state_d = PRESENT;
         PRESENT: if (bus.tri_ready) state_d = last ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.list_clear)
         state_d = IDLE;
   end

   // Pass bookkeeping and output register; frame length is frozen at
   // frame_start so writes during a pass do not extend it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         idx_q       <= '0;
         frame_len_q <= '0;
         tri_out_q   <= '0;
      end else if (!bus.list_clear) begin
         if (state_q == IDLE && bus.frame_start) begin
            frame_len_q <= cnt_q;
            idx_q       <= '0;
         end
         if (state_q == FETCH)
            tri_out_q <= mem[idx_q];
         if (state_q == PRESENT && bus.tri_ready && !last)
            idx_q <= idx_q + AW'(1);
      end
   end
endmodule

// File: tb/tb_triangle_list.sv
// Scoreboard bench for triangle_list: stimulus pushes the expected readout
// order into a queue, a monitor pops and compares on every handshake.
module tb_triangle_list;
   localparam int WI    = 8;
   localparam int WF    = 8;
   localparam int DEPTH = 16;

   typedef logic [2:0][WI+WF-1:0]      vtx_t;
   typedef logic [2:0][2:0][WI+WF-1:0] tri_t;

   logic Clk = 1'b0;
   logic Reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;
   tri_t exp_q[$];

   always #5 Clk = ~Clk;

   triangle_list_if #(.WI(WI), .WF(WF), .DEPTH(DEPTH)) dif ();

   triangle_list #(.WI(WI), .WF(WF), .DEPTH(DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (dif)
   );

   // Unit-cube corner v = x + 2y + 4z in 8.8 fixed point (1.0 = 0x0100).
   function automatic vtx_t corner(input int v);
      vtx_t p;
      p[0] = ((v & 1) != 0) ? 16'h0100 : 16'h0000;
      p[1] = ((v & 2) != 0) ? 16'h0100 : 16'h0000;
      p[2] = ((v & 4) != 0) ? 16'h0100 : 16'h0000;
      return p;
   endfunction

   function automatic tri_t cube_tri(input int k);
      int a, b, c;
      tri_t t;
      case (k)
         0:  begin a = 0; b = 1; c = 3; end
         1:  begin a = 0; b = 3; c = 2; end
         2:  begin a = 4; b = 5; c = 7; end
         3:  begin a = 4; b = 7; c = 6; end
         4:  begin a = 0; b = 1; c = 5; end
         5:  begin a = 0; b = 5; c = 4; end
         6:  begin a = 2; b = 3; c = 7; end
         7:  begin a = 2; b = 7; c = 6; end
         8:  begin a = 0; b = 2; c = 6; end
         9:  begin a = 0; b = 6; c = 4; end
         10: begin a = 1; b = 3; c = 7; end
         default: begin a = 1; b = 7; c = 5; end
      endcase
      t[0] = corner(a);
      t[1] = corner(b);
      t[2] = corner(c);
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input tri_t t);
      dif.list_w           = 1'b1;
      dif.orig_triangle_in = t;
      tick();
      dif.list_w = 1'b0;
   endtask

   // Waits (bounded) for a frame_done pulse, then confirms exactly one and
   // that every expected triangle was consumed.
   task automatic wait_done(input int budget, input string name);
      int start = done_cnt;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clk);
         if (done_cnt != start) break;
      end
      repeat (3) @(posedge Clk);
      #1;
      chk({name, "_done_pulses"}, 32'(done_cnt - start), 32'd1);
      chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Ready-gated pass: one handshake per triangle; optional long stall at
   // index stall_at, or list_clear while index clear_at is presented.
   task automatic step_pass(input int n_hs, input int stall_at, input int clear_at);
      int   t;
      bit   stable;
      tri_t cap;
      for (int k = 0; k < n_hs; k++) begin
         t = 0;
         @(negedge Clk);
         while (!dif.tri_valid && t < 50) begin
            @(negedge Clk);
            t++;
         end
         if (!dif.tri_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
            return;
         end
         if (k == stall_at) begin
            cap    = dif.tri_out;
            stable = 1'b1;
            repeat (10) begin
               @(negedge Clk);
               if (dif.tri_out !== cap || dif.tri_valid !== 1'b1) stable = 1'b0;
            end
            chk("stall_stable", 32'(stable), 32'd1);
         end
         tick();
         if (k == clear_at) begin
            dif.list_clear = 1'b1;
            tick();
            dif.list_clear = 1'b0;
            return;
         end
         dif.tri_ready = 1'b1;
         tick();
         dif.tri_ready = 1'b0;
      end
   endtask

   // Monitor: counts frame_done pulses and checks each handshake in order.
   always @(negedge Clk) begin
      tri_t e;
      if (Reset === 1'b0) begin
         if (dif.frame_done) done_cnt++;
         if (dif.tri_valid && dif.tri_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL handshake: got %h expected no triangle", dif.tri_out);
            end else begin
               e = exp_q.pop_front();
               if (dif.tri_out !== e) begin
                  n_errors++;
                  $display("FAIL handshake: got %h expected %h", dif.tri_out, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      tri_t t1, t2, t3;
      int   d0;
      int   exp_cnt;
      Reset                = 1'b1;
      dif.list_w           = 1'b0;
      dif.orig_triangle_in = '0;
      dif.list_clear       = 1'b0;
      dif.frame_start      = 1'b0;
      dif.tri_ready        = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_count", 32'(dif.tri_count), 32'd0);
      chk("rst_full", 32'(dif.full), 32'd0);
      chk("rst_overflow", 32'(dif.overflow), 32'd0);
      chk("rst_valid", 32'(dif.tri_valid), 32'd0);
      chk("rst_done", 32'(dif.frame_done), 32'd0);
      chk("rst_tri_out_zero", 32'(dif.tri_out == '0), 32'd1);
      tick();
      Reset = 1'b0;

      // Cube pass at full throughput, latency check.
      for (int k = 0; k < 12; k++) wr(cube_tri(k));
      @(negedge Clk);
      chk("cube_count", 32'(dif.tri_count), 32'd12);
      chk("cube_full", 32'(dif.full), 32'd0);
      for (int k = 0; k < 12; k++) exp_q.push_back(cube_tri(k));
      tick();
      dif.tri_ready   = 1'b1;
      dif.frame_start = 1'b1;
      tick();
      dif.frame_start = 1'b0;
      @(negedge Clk);
      chk("lat_cycle1_valid", 32'(dif.tri_valid), 32'd0);
      @(negedge Clk);
      chk("lat_cycle2_valid", 32'(dif.tri_valid), 32'd1);
      wait_done(100, "cube");
      dif.tri_ready = 1'b0;

      // Back-pressure: 10-cycle stall on triangle 3.
      for (int k = 0; k < 12; k++) exp_q.push_back(cube_tri(k));
      dif.frame_start = 1'b1;
      tick();
      dif.frame_start = 1'b0;
      step_pass(12, 3, -1);
      wait_done(20, "stall");

      // list_clear while triangle 5 is presented.
      for (int k = 0; k < 5; k++) exp_q.push_back(cube_tri(k));
      d0 = done_cnt;
      dif.frame_start = 1'b1;
      tick();
      dif.frame_start = 1'b0;
      step_pass(6, -1, 5);
      @(negedge Clk);
      chk("clr_valid", 32'(dif.tri_valid), 32'd0);
      chk("clr_count", 32'(dif.tri_count), 32'd0);
      repeat (5) @(posedge Clk);
      #1;
      chk("clr_no_done", 32'(done_cnt - d0), 32'd0);
      chk("clr_queue_left", 32'(exp_q.size()), 32'd0);

      // Empty list: immediate frame_done, no triangle.
      dif.frame_start = 1'b1;
      tick();
      dif.frame_start = 1'b0;
      @(negedge Clk);
      chk("empty_done", 32'(dif.frame_done), 32'd1);
      chk("empty_valid", 32'(dif.tri_valid), 32'd0);
      @(negedge Clk);
      chk("empty_done_once", 32'(dif.frame_done), 32'd0);
      tick();

      // Fill to DEPTH, one dropped write, readout, then clear beats write.
      for (int k = 0; k < 16; k++) wr(cube_tri(k % 12));
      @(negedge Clk);
      chk("fill_count", 32'(dif.tri_count), 32'd16);
      chk("fill_full", 32'(dif.full), 32'd1);
      chk("fill_overflow", 32'(dif.overflow), 32'd0);
      tick();
      wr(cube_tri(5));
      @(negedge Clk);
      chk("ovf_count", 32'(dif.tri_count), 32'd16);
      chk("ovf_flag", 32'(dif.overflow), 32'd1);
      for (int k = 0; k < 16; k++) exp_q.push_back(cube_tri(k % 12));
      tick();
      dif.tri_ready   = 1'b1;
      dif.frame_start = 1'b1;
      tick();
      dif.frame_start = 1'b0;
      wait_done(120, "fill");
      dif.tri_ready = 1'b0;
      chk("ovf_sticky", 32'(dif.overflow), 32'd1);
      dif.list_clear       = 1'b1;
      dif.list_w           = 1'b1;
      dif.orig_triangle_in = cube_tri(0);
      tick();
      dif.list_clear = 1'b0;
      dif.list_w     = 1'b0;
      @(negedge Clk);
      chk("clear_count", 32'(dif.tri_count), 32'd0);
      chk("clear_overflow", 32'(dif.overflow), 32'd0);
      chk("clear_full", 32'(dif.full), 32'd0);
      tick();

      // Degenerate filter, plus a write landing with frame_start.
      t1[0] = corner(1); t1[1] = corner(1); t1[2] = corner(2);
      t2[0] = corner(1); t2[1] = corner(2); t2[2] = corner(4);
      t3    = cube_tri(7);
      wr(t1);
      wr(t2);
`ifdef TRI_LIST_SKIP_DEGENERATE_EN
      exp_cnt = 1;
      exp_q.push_back(t2);
`else
      exp_cnt = 2;
      exp_q.push_back(t1);
      exp_q.push_back(t2);
`endif
      @(negedge Clk);
      chk("degen_count", 32'(dif.tri_count), 32'(exp_cnt));
      tick();
      dif.tri_ready        = 1'b1;
      dif.frame_start      = 1'b1;
      dif.list_w           = 1'b1;
      dif.orig_triangle_in = t3;
      tick();
      dif.frame_start = 1'b0;
      dif.list_w      = 1'b0;
      wait_done(40, "midpass");
      chk("midpass_count", 32'(dif.tri_count), 32'(exp_cnt + 1));
      dif.tri_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/triangle_list.md
TRIANGLE_LIST -- requirements
Module: triangle_list

Interface
REQ-001 SHALL have parameter WI, default 8, integer bits per coordinate.
REQ-002 SHALL have parameter WF, default 8, fractional bits per coordinate.
REQ-003 SHALL have parameter DEPTH, default 16, maximum stored triangles; AW = clog2(DEPTH).
REQ-004 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port list_w  input  1  write strobe, one triangle per asserted cycle.
REQ-007 SHALL have port orig_triangle_in  input  [2:0][2:0][WI+WF-1:0]  triangle to store, 3 vertices x (x,y,z).
REQ-008 SHALL have port list_clear  input  1  empties list, clears overflow, aborts readout.
REQ-009 SHALL have port frame_start  input  1  begins one in-order readout pass.
REQ-010 SHALL have port tri_ready  input  1  downstream accepts tri_out.
REQ-011 SHALL have port tri_out  output  [2:0][2:0][WI+WF-1:0]  triangle presented downstream.
REQ-012 SHALL have port tri_valid  output  1  tri_out valid.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse ending a pass.
REQ-014 SHALL have port tri_count  output  AW+1  number of stored triangles.
REQ-015 SHALL have port full  output  1  tri_count == DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky: a write was dropped while full.

Function
REQ-017 SHALL store orig_triangle_in at index tri_count and increment tri_count on a cycle with list_w=1, full=0, list_clear=0.
REQ-018 SHALL drop writes while full and set overflow, which holds until list_clear or Reset.
REQ-019 SHALL give list_clear priority over list_w in the same cycle: write dropped, tri_count=0 next cycle.
REQ-020 SHALL implement readout FSM states Idle, Fetch, Present, Done.
REQ-021 Idle: frame_start=1 with tri_count>0 -> latch frame_len=tri_count, idx=0, go Fetch; with tri_count=0 -> go Done; frame_start elsewhere ignored.
REQ-022 Fetch: synchronous read of entry idx, go Present; tri_valid=0.
REQ-023 Present: tri_valid=1, tri_out stable until tri_ready=1; on handshake, idx==frame_len-1 -> Done, else idx+1 -> Fetch.
REQ-024 Done: frame_done=1 for exactly one cycle, go Idle.
REQ-025 SHALL use frame_len latched at frame_start; writes during a pass are stored but not output in that pass.
REQ-026 SHALL, on list_clear in any state, go Idle next cycle with tri_valid=0 and no frame_done.
REQ-027 SHALL hold tri_out unchanged whenever tri_valid=0 and not Present.

Reset
REQ-028 SHALL on Reset force: state Idle, tri_count=0, idx=0, frame_len=0, overflow=0, tri_valid=0, frame_done=0, tri_out=0, full=0.
REQ-029 SHALL not require storage array contents to be reset; unread entries are never output.
REQ-030 SHALL abandon an in-progress pass on Reset without frame_done.

Configuration
REQ-031 SHALL, with macro TRI_LIST_SKIP_DEGENERATE_EN defined, drop (without setting overflow or incrementing tri_count) any written triangle with two bit-identical vertices.
REQ-032 SHALL, without TRI_LIST_SKIP_DEGENERATE_EN, store all non-overflowing writes unchanged.

Verification
REQ-033 Write 12 cube triangles on consecutive cycles, tri_ready=1, frame_start -> tri_count=12, 12 valid handshakes in write order, first tri_valid 2 cycles after frame_start, frame_done once.
REQ-034 Hold tri_ready=0 10 cycles on triangle 3 -> tri_out and tri_valid stable throughout, resume order unchanged.
REQ-035 DEPTH=16, 17 writes -> tri_count=16, full=1, overflow=1; list_clear -> tri_count=0, overflow=0, full=0.
REQ-036 frame_start with tri_count=0 -> no tri_valid, frame_done pulse 1 cycle after frame_start.
REQ-037 list_clear during Present of triangle 5 -> tri_valid=0 next cycle, no frame_done, Idle.
REQ-038 With TRI_LIST_SKIP_DEGENERATE_EN, write {P1,P1,P2} then {P1,P2,P3} -> tri_count=1; without it -> tri_count=2.
